// File: rtl/c_stage_mem.sv
// Memory pipeline stage: issues loads/stores over a valid/ready request channel and retires to writeback.
// Optional macro C_MISALIGN_TRAP_EN turns misaligned accesses into flagged retirements instead of masking them.
module c_stage_mem #(
  parameter int XLEN      = 32,
  parameter int REG_SEL_W = 5,
  parameter int BE_W      = XLEN / 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ac_valid,
  output logic                 ac_ready,
  input  logic [XLEN-1:0]      ac_pc,
  input  logic [REG_SEL_W-1:0] ac_write_sel,
  input  logic [XLEN-1:0]      ac_result,
  input  logic [XLEN-1:0]      ac_store_data,
  input  logic [2:0]           ac_funct3,
  input  logic                 ac_is_load,
  input  logic                 ac_is_store,
  input  logic                 ac_is_wb,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic                 mem_req_we,
  output logic [XLEN-1:0]      mem_req_addr,
  output logic [XLEN-1:0]      mem_req_wdata,
  output logic [BE_W-1:0]      mem_req_be,
  input  logic                 mem_resp_valid,
  input  logic [XLEN-1:0]      mem_resp_rdata,
  output logic                 cw_valid,
  output logic [XLEN-1:0]      cw_pc,
  output logic [REG_SEL_W-1:0] cw_write_sel,
  output logic [XLEN-1:0]      cw_result,
  output logic                 cw_is_wb,
  output logic                 cw_misalign
);

  localparam int LANE_W = $clog2(BE_W);
  localparam bit IS64   = (XLEN == 64);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t                 state_reg;
  logic [XLEN-1:0]        pc_reg;
  logic [REG_SEL_W-1:0]   sel_reg;
  logic [XLEN-1:0]        addr_reg;
  logic                   is_wb_reg;
  logic                   is_ld_reg;
  logic [LANE_W-1:0]      lane_reg;
  logic [1:0]             size_reg;
  logic                   unsigned_reg;

  logic [2:0]             f3_eff;
  logic [1:0]             size_sel;
  logic [LANE_W-1:0]      lo_mask;
  logic [LANE_W-1:0]      lane_sel;
  logic [7:0]             size_be8;
  logic [BE_W-1:0]        be_next;
  logic [XLEN-1:0]        addr_next;
  logic [BE_W-1:0][7:0]   st_lane;
  logic                   is_mem;
  logic [XLEN-1:0]        ld_shift;
  logic [XLEN-1:0]        ld_keep;
  logic                   ld_sign;
  logic [XLEN-1:0]        ld_data;

  assign ac_ready = (state_reg == IDLE);
  assign is_mem   = ac_is_load | ac_is_store;

  // Double-word and LWU encodings fold to a plain word access on 32-bit builds.
  always_comb begin
    f3_eff = ac_funct3;
    if (!IS64 && (ac_funct3 == 3'b011 || ac_funct3 == 3'b110))
      f3_eff = 3'b010;
    size_sel = f3_eff[1:0];
    case (size_sel)
      2'd0:    begin lo_mask = '0;           size_be8 = 8'h01; end
      2'd1:    begin lo_mask = LANE_W'(1);   size_be8 = 8'h03; end
      2'd2:    begin lo_mask = LANE_W'(3);   size_be8 = 8'h0F; end
      default: begin lo_mask = LANE_W'(7);   size_be8 = 8'hFF; end
    endcase
    lane_sel  = ac_result[LANE_W-1:0] & ~lo_mask;
    be_next   = BE_W'(size_be8) << lane_sel;
    addr_next = {ac_result[XLEN-1:LANE_W], {LANE_W{1'b0}}};
  end

  // Every lane carries the store byte it would hold if the access were placed there.
  genvar gi;
  generate
    for (gi = 0; gi < BE_W; gi++) begin : g_st_lane
      assign st_lane[gi] = (size_sel == 2'd0) ? ac_store_data[7:0] :
                           (size_sel == 2'd1) ? ac_store_data[8*(gi%2) +: 8] :
                           (size_sel == 2'd2) ? ac_store_data[8*(gi%4) +: 8] :
                                                ac_store_data[8*(gi%8) +: 8];
    end
  endgenerate

  always_comb begin
    ld_shift = mem_resp_rdata >> {lane_reg, 3'b000};
    case (size_reg)
      2'd0:    begin ld_keep = XLEN'(8'hFF);         ld_sign = ld_shift[7];  end
      2'd1:    begin ld_keep = XLEN'(16'hFFFF);      ld_sign = ld_shift[15]; end
      2'd2:    begin ld_keep = XLEN'(32'hFFFF_FFFF); ld_sign = ld_shift[31]; end
      default: begin ld_keep = '1;                   ld_sign = 1'b0;         end
    endcase
    ld_data = ld_shift & ld_keep;
    if (!unsigned_reg && ld_sign)
      ld_data = ld_data | ~ld_keep;
  end

`ifdef C_MISALIGN_TRAP_EN
  logic misalign;
  logic trap_take;
  logic retire_take;

  assign misalign    = |(ac_result[LANE_W-1:0] & lo_mask);
  assign trap_take   = (state_reg == IDLE) && ac_valid && is_mem && misalign;
  assign retire_take = ((state_reg == IDLE) && ac_valid && (!is_mem || misalign)) ||
                       ((state_reg == REQ)  && mem_req_ready && !is_ld_reg) ||
                       ((state_reg == WAIT) && mem_resp_valid);

  // The flag belongs to the most recent retirement only.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      cw_misalign <= 1'b0;
    else if (retire_take)
      cw_misalign <= trap_take;
  end
`else
  assign cw_misalign = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      pc_reg        <= '0;
      sel_reg       <= '0;
      addr_reg      <= '0;
      is_wb_reg     <= 1'b0;
      is_ld_reg     <= 1'b0;
      lane_reg      <= '0;
      size_reg      <= '0;
      unsigned_reg  <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_be    <= '0;
      cw_valid      <= 1'b0;
      cw_pc         <= '0;
      cw_write_sel  <= '0;
      cw_result     <= '0;
      cw_is_wb      <= 1'b0;
    end else begin
      cw_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (ac_valid) begin
            if (!is_mem) begin
              cw_valid     <= 1'b1;
              cw_pc        <= ac_pc;
              cw_write_sel <= ac_write_sel;
              cw_result    <= ac_result;
              cw_is_wb     <= ac_is_wb;
            end
`ifdef C_MISALIGN_TRAP_EN
            else if (trap_take) begin
              cw_valid     <= 1'b1;
              cw_pc        <= ac_pc;
              cw_write_sel <= ac_write_sel;
              cw_result    <= ac_result;
              cw_is_wb     <= 1'b0;
            end
`endif
            else begin
              pc_reg        <= ac_pc;
              sel_reg       <= ac_write_sel;
              addr_reg      <= ac_result;
              is_wb_reg     <= ac_is_wb;
              is_ld_reg     <= ac_is_load;
              lane_reg      <= lane_sel;
              size_reg      <= size_sel;
              unsigned_reg  <= f3_eff[2];
              mem_req_valid <= 1'b1;
              mem_req_we    <= ~ac_is_load;
              mem_req_addr  <= addr_next;
              mem_req_wdata <= st_lane;
              mem_req_be    <= be_next;
              state_reg     <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            if (is_ld_reg) begin
              state_reg <= WAIT;
            end else begin
              cw_valid     <= 1'b1;
              cw_pc        <= pc_reg;
              cw_write_sel <= sel_reg;
              cw_result    <= addr_reg;
              cw_is_wb     <= 1'b0;
              state_reg    <= IDLE;
            end
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            cw_valid     <= 1'b1;
            cw_pc        <= pc_reg;
            cw_write_sel <= sel_reg;
            cw_result    <= ld_data;
            cw_is_wb     <= is_wb_reg;
            state_reg    <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
